// File: rtl/vid_scanner.sv
// Gigatron video address generator: follows the sync bits and emits pixel fetch address and slot count.
// Latency: VADDR/VCNT are valid one CLK after the final porch strobe; the first fetch uses them on the next strobe.
// Backpressure: none upstream; PIXEN=0 freezes every register. Option macro: VID_SCANNER_HSCROLL_EN adds HSCROLL.
module vid_scanner #(
    parameter int          HSTART = 12,
    parameter int          WIDTH  = 160,
    parameter int          VSTART = 34,
    parameter int          NROWS  = 120,
    parameter int          LREP   = 4,
    parameter logic [7:0]  PAGE0  = 8'h08
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        VRUN,
    input  logic        HDBL,
    input  logic        PIXEN,
    input  logic [1:0]  SYNC,
`ifdef VID_SCANNER_HSCROLL_EN
    input  logic [7:0]  HSCROLL,
`endif
    output logic [15:0] VADDR,
    output logic [6:0]  VCNT,
    output logic        VACTIVE,
    output logic [6:0]  ROW
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VBLANK = 3'd1,
        HWAIT  = 3'd2,
        HPORCH = 3'd3,
        ACTIVE = 3'd4
    } state_t;

    localparam logic [7:0] VSTART_M1 = 8'(VSTART - 1);
    localparam logic [7:0] HSTART_L  = 8'(HSTART);
    localparam logic [7:0] WIDTH_M1  = 8'(WIDTH - 1);
    localparam logic [6:0] VCNT_FULL = 7'(WIDTH / 2);
    localparam logic [6:0] VCNT_DBL  = 7'(WIDTH / 4);
    localparam logic [3:0] LREP_L    = 4'(LREP);
    localparam logic [6:0] NROWS_L   = 7'(NROWS);

    state_t      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic [7:0]  lcnt_q, lcnt_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [7:0]  pix_q, pix_d;
    logic [3:0]  sub_q, sub_d;
    logic [6:0]  row_q, row_d;
    logic [15:0] vaddr_q, vaddr_d;
    logic [6:0]  vcnt_q, vcnt_d;
    logic        vactive_q, vactive_d;

    logic        vs_rise, vs_fall, hs_rise, hs_fall, hs_edge;
    logic [3:0]  sub_inc;
    logic [6:0]  row_inc;
    logic        end_of_row, end_of_frame;
    logic [7:0]  row_page;
    logic [7:0]  col_start;
    logic        addr_adv, fetch_slot;

    // Edge detection against the sync history; only meaningful on a pixel strobe.
    assign vs_rise = PIXEN &  SYNC[1] & ~sync_q[1];
    assign vs_fall = PIXEN & ~SYNC[1] &  sync_q[1];
    assign hs_rise = PIXEN &  SYNC[0] & ~sync_q[0];
    assign hs_fall = PIXEN & ~SYNC[0] &  sync_q[0];
    assign hs_edge = hs_rise | hs_fall;

    // Line-end bookkeeping shared by the natural end and the hsync truncation.
    assign sub_inc      = sub_q + 4'd1;
    assign row_inc      = row_q + 7'd1;
    assign end_of_row   = (sub_inc == LREP_L);
    assign end_of_frame = end_of_row && (row_inc == NROWS_L);

    // Row page wraps modulo 256.
    assign row_page = PAGE0 + {1'b0, row_q};

`ifdef VID_SCANNER_HSCROLL_EN
    assign col_start = HSCROLL;
`else
    assign col_start = 8'h00;
`endif

    // Doubled mode halves both address rate and fetch rate; pix_q counts strobes already taken.
    assign addr_adv   = HDBL ? pix_q[0] : 1'b1;
    assign fetch_slot = HDBL ? (pix_q[1:0] == 2'b11) : pix_q[0];

    // State register and datapath registers.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            lcnt_q    <= 8'd0;
            pcnt_q    <= 8'd0;
            pix_q     <= 8'd0;
            sub_q     <= 4'd0;
            row_q     <= 7'd0;
            vaddr_q   <= 16'h0000;
            vcnt_q    <= 7'd0;
            vactive_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            lcnt_q    <= lcnt_d;
            pcnt_q    <= pcnt_d;
            pix_q     <= pix_d;
            sub_q     <= sub_d;
            row_q     <= row_d;
            vaddr_q   <= vaddr_d;
            vcnt_q    <= vcnt_d;
            vactive_q <= vactive_d;
        end
    end

    // Next-state and datapath updates; priority is VRUN drop, then vsync abort, then the per-state work.
    always_comb begin
        state_d   = state_q;
        sync_d    = sync_q;
        lcnt_d    = lcnt_q;
        pcnt_d    = pcnt_q;
        pix_d     = pix_q;
        sub_d     = sub_q;
        row_d     = row_q;
        vaddr_d   = vaddr_q;
        vcnt_d    = vcnt_q;
        vactive_d = vactive_q;

        if (PIXEN) begin
            sync_d = SYNC;
            if (!VRUN) begin
                state_d   = IDLE;
                vcnt_d    = 7'd0;
                vactive_d = 1'b0;
                row_d     = 7'd0;
                pix_d     = 8'd0;
            end else if (vs_fall && (state_q != IDLE)) begin
                state_d   = VBLANK;
                lcnt_d    = 8'd0;
                vcnt_d    = 7'd0;
                vactive_d = 1'b0;
                pix_d     = 8'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (vs_rise) begin
                            state_d = VBLANK;
                            lcnt_d  = 8'd0;
                        end
                    end
                    VBLANK: begin
                        // The VSTART-th hsync ends blanking and also opens the first visible line.
                        if (hs_rise) begin
                            if (lcnt_q == VSTART_M1) begin
                                state_d = HPORCH;
                                pcnt_d  = HSTART_L;
                                row_d   = 7'd0;
                                sub_d   = 4'd0;
                            end else begin
                                lcnt_d = lcnt_q + 8'd1;
                            end
                        end
                    end
                    HWAIT: begin
                        if (hs_rise) begin
                            state_d = HPORCH;
                            pcnt_d  = HSTART_L;
                        end
                    end
                    HPORCH: begin
                        if (pcnt_q <= 8'd1) begin
                            state_d   = ACTIVE;
                            vaddr_d   = {row_page, col_start};
                            vcnt_d    = HDBL ? VCNT_DBL : VCNT_FULL;
                            vactive_d = 1'b1;
                            pix_d     = 8'd0;
                            pcnt_d    = 8'd0;
                        end else begin
                            pcnt_d = pcnt_q - 8'd1;
                        end
                    end
                    ACTIVE: begin
                        if (hs_edge || (pix_q == WIDTH_M1)) begin
                            vactive_d = 1'b0;
                            vcnt_d    = 7'd0;
                            pix_d     = 8'd0;
                            state_d   = HWAIT;
                            if (end_of_row) begin
                                sub_d = 4'd0;
                                if (end_of_frame) begin
                                    row_d   = 7'd0;
                                    state_d = IDLE;
                                end else begin
                                    row_d = row_inc;
                                end
                            end else begin
                                sub_d = sub_inc;
                            end
                        end else begin
                            pix_d = pix_q + 8'd1;
                            // Column wraps inside the page; the page byte is never touched here.
                            if (addr_adv) begin
                                vaddr_d[7:0] = vaddr_q[7:0] + 8'd1;
                            end
                            if (fetch_slot && (vcnt_q != 7'd0)) begin
                                vcnt_d = vcnt_q - 7'd1;
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    assign VADDR   = vaddr_q;
    assign VCNT    = vcnt_q;
    assign VACTIVE = vactive_q;
    assign ROW     = row_q;

endmodule

// File: tb/tb_vid_scanner.sv
// Directed bench for vid_scanner: frame start, full lines in both modes, row stepping, frame end,
// vsync abort, sync priority, VRUN drop, optional horizontal scroll and asynchronous reset.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_vid_scanner;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        VRUN;
    logic        HDBL;
    logic        PIXEN;
    logic [1:0]  SYNC;
    logic [15:0] VADDR;
    logic [6:0]  VCNT;
    logic        VACTIVE;
    logic [6:0]  ROW;
`ifdef VID_SCANNER_HSCROLL_EN
    logic [7:0]  HSCROLL;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vid_scanner dut (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .VRUN    (VRUN),
        .HDBL    (HDBL),
        .PIXEN   (PIXEN),
        .SYNC    (SYNC),
`ifdef VID_SCANNER_HSCROLL_EN
        .HSCROLL (HSCROLL),
`endif
        .VADDR   (VADDR),
        .VCNT    (VCNT),
        .VACTIVE (VACTIVE),
        .ROW     (ROW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic vsync_pulse();
        SYNC[1] = 1'b0;
        tick(1);
        SYNC[1] = 1'b1;
        tick(1);
    endtask

    task automatic hsync_pulse();
        SYNC[0] = 1'b0;
        tick(1);
        SYNC[0] = 1'b1;
        tick(1);
    endtask

    // From IDLE: vsync, 34 hsyncs, 12 porch strobes -> row 0 line active at its first pixel.
    task automatic start_frame();
        vsync_pulse();
        repeat (34) hsync_pulse();
        tick(12);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 1'b0;
        VRUN   = 1'b1;
        HDBL   = 1'b0;
        PIXEN  = 1'b1;
        SYNC   = 2'b11;
`ifdef VID_SCANNER_HSCROLL_EN
        HSCROLL = 8'h00;
`endif
        #3;
        check("rst_vaddr",   32'(VADDR),   32'h0);
        check("rst_vcnt",    32'(VCNT),    32'h0);
        check("rst_vactive", 32'(VACTIVE), 32'h0);
        check("rst_row",     32'(ROW),     32'h0);
        tick(2);
        nRESET = 1'b1;
        tick(1);

        // Frame start: one strobe before the porch ends nothing is active yet.
        vsync_pulse();
        repeat (34) hsync_pulse();
        tick(11);
        check("porch_not_done", 32'(VACTIVE), 32'h0);
        tick(1);
        check("start_vaddr",   32'(VADDR),   32'h0800);
        check("start_vcnt",    32'(VCNT),    80);
        check("start_vactive", 32'(VACTIVE), 32'h1);
        check("start_row",     32'(ROW),     32'h0);

        // Line 1, single-width: low byte follows the strobe count, VCNT drops every second strobe.
        for (int k = 1; k <= 159; k++) begin
            tick(1);
            check("walk_vaddr", 32'(VADDR), 32'h0800 + k);
            if (k == 10 || k == 159)
                check("walk_vcnt", 32'(VCNT), 80 - k / 2);
            if (k == 10) begin
                PIXEN = 1'b0;
                tick(3);
                check("hold_vaddr", 32'(VADDR), 32'h080A);
                check("hold_vcnt",  32'(VCNT),  75);
                PIXEN = 1'b1;
            end
        end
        tick(1);
        check("end1_vactive", 32'(VACTIVE), 32'h0);
        check("end1_vcnt",    32'(VCNT),    32'h0);
        check("end1_vaddr",   32'(VADDR),   32'h089F);

        // Line 2, doubled: address every second strobe, VCNT every fourth.
        HDBL = 1'b1;
        hsync_pulse();
        tick(12);
        check("dbl_vcnt0",  32'(VCNT),  40);
        check("dbl_vaddr0", 32'(VADDR), 32'h0800);
        for (int k = 1; k <= 159; k++) begin
            tick(1);
            check("dbl_vaddr", 32'(VADDR), 32'h0800 + k / 2);
            if (k == 3 || k == 4 || k == 159)
                check("dbl_vcnt", 32'(VCNT), 40 - k / 4);
        end
        tick(1);
        check("end2_vactive", 32'(VACTIVE), 32'h0);
        check("end2_vaddr",   32'(VADDR),   32'h084F);
        HDBL = 1'b0;

        // Lines 3 and 4 are cut short by the next hsync.
        hsync_pulse();
        tick(17);
        hsync_pulse();
        tick(17);
        check("line4_vaddr", 32'(VADDR), 32'h0805);
        check("line4_row",   32'(ROW),   32'h0);
        SYNC[0] = 1'b0;
        tick(1);
        check("trunc_vactive", 32'(VACTIVE), 32'h0);
        check("trunc_vcnt",    32'(VCNT),    32'h0);
        check("trunc_row",     32'(ROW),     32'h1);
        SYNC[0] = 1'b1;
        tick(1);
        tick(12);
        check("row1_vaddr", 32'(VADDR), 32'h0900);
        check("row1_row",   32'(ROW),   32'h1);

        // Remaining lines 6..480 as short lines.
        for (int ln = 6; ln <= 480; ln++) begin
            hsync_pulse();
            tick(14);
        end
        check("last_row",   32'(ROW),   119);
        check("last_vaddr", 32'(VADDR), 32'h7F02);
        SYNC[0] = 1'b0;
        tick(1);
        check("frame_end_vactive", 32'(VACTIVE), 32'h0);
        SYNC[0] = 1'b1;
        tick(1);
        tick(20);
        check("idle_no_line", 32'(VACTIVE), 32'h0);
        check("idle_vcnt",    32'(VCNT),    32'h0);
        hsync_pulse();
        tick(20);
        check("idle_hsync_no_line", 32'(VACTIVE), 32'h0);

        // Vsync falling at pixel 50 aborts to blanking with the line count restarted.
        start_frame();
        tick(50);
        check("px50_vaddr", 32'(VADDR), 32'h0832);
        check("px50_vcnt",  32'(VCNT),  55);
        SYNC[1] = 1'b0;
        tick(1);
        check("abort_vactive", 32'(VACTIVE), 32'h0);
        check("abort_vcnt",    32'(VCNT),    32'h0);
        SYNC[1] = 1'b1;
        tick(1);
        repeat (33) hsync_pulse();
        tick(12);
        check("abort_still_blank", 32'(VACTIVE), 32'h0);
        hsync_pulse();
        tick(12);
        check("abort_restart_vactive", 32'(VACTIVE), 32'h1);
        check("abort_restart_vaddr",   32'(VADDR),   32'h0800);

        // Simultaneous vsync and hsync falls: vsync wins, so a following hsync starts no line.
        tick(3);
        SYNC = 2'b00;
        tick(1);
        check("dual_vactive", 32'(VACTIVE), 32'h0);
        check("dual_vcnt",    32'(VCNT),    32'h0);
        SYNC = 2'b11;
        tick(1);
        hsync_pulse();
        tick(12);
        check("vs_priority", 32'(VACTIVE), 32'h0);

        // VRUN drop mid-line clears outputs and the row; IDLE then waits for vsync.
        VRUN = 1'b0;
        tick(1);
        VRUN = 1'b1;
        start_frame();
        repeat (4) begin
            hsync_pulse();
            tick(14);
        end
        check("vrun_pre_row", 32'(ROW), 32'h1);
        VRUN = 1'b0;
        tick(1);
        check("vrun_vactive", 32'(VACTIVE), 32'h0);
        check("vrun_vcnt",    32'(VCNT),    32'h0);
        check("vrun_row",     32'(ROW),     32'h0);
        VRUN = 1'b1;
        hsync_pulse();
        tick(14);
        check("vrun_idle", 32'(VACTIVE), 32'h0);

`ifdef VID_SCANNER_HSCROLL_EN
        // Scrolled row start wraps inside the page.
        HSCROLL = 8'hF0;
        start_frame();
        check("scroll_start", 32'(VADDR), 32'h08F0);
        tick(15);
        check("scroll_ff", 32'(VADDR), 32'h08FF);
        tick(1);
        check("scroll_wrap", 32'(VADDR), 32'h0800);
        HSCROLL = 8'h00;
        VRUN = 1'b0;
        tick(1);
        VRUN = 1'b1;
`endif

        // Asynchronous reset in the middle of a line, between clock edges.
        start_frame();
        tick(5);
        check("pre_rst_vaddr", 32'(VADDR), 32'h0805);
        nRESET = 1'b0;
        #2;
        check("arst_vaddr",   32'(VADDR),   32'h0);
        check("arst_vcnt",    32'(VCNT),    32'h0);
        check("arst_vactive", 32'(VACTIVE), 32'h0);
        check("arst_row",     32'(ROW),     32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
